// File: rtl/polyvec_coeff_feeder.sv
// Serial coefficient stream to (even, odd) pair writes for the polyvec basemul accumulator.
// Fills vector A (K polys) and then vector B. Each coefficient is reduced once by q on entry.
module polyvec_coeff_feeder #(
  parameter int unsigned N     = 256,
  parameter int unsigned K     = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned Q     = 3329
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             s_valid,
  input  logic [15:0]      s_data,
  output logic             s_ready,
  output logic [15:0]      vec_din_1,
  output logic [15:0]      vec_din_2,
  output logic [DEPTH-1:0] vec_index,
  output logic [1:0]       vec_sel,
  output logic             vec_we_a,
  output logic             vec_we_b,
  output logic             busy,
  output logic             load_done,
  output logic             err
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = DEPTH - 1;
  localparam logic [DW-1:0] Q_W    = DW'(Q);
  localparam logic [DW-1:0] Q2_W   = DW'(2 * Q);
  localparam logic [PW-1:0] PAIR_L = PW'(N / 2 - 1);
  localparam logic [1:0]    SEL_L  = 2'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_FIN} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pair_cnt;
  logic [1:0]    sel_cnt;
  logic          side_b;
  logic [DW-1:0] lo_q;

  logic          accept_c;
  logic          ge_q_c;
  logic          ge_2q_c;
  logic [DW-1:0] red_c;
  logic          pair_wrap_c;
  logic          sel_wrap_c;
  logic          last_pair_c;

  // Single conditional subtraction; values >= 2q are flagged, not fully reduced.
  always_comb begin
    accept_c    = s_valid & s_ready;
    ge_q_c      = s_data >= Q_W;
    ge_2q_c     = s_data >= Q2_W;
    red_c       = ge_q_c ? s_data - Q_W : s_data;
    pair_wrap_c = pair_cnt == PAIR_L;
    sel_wrap_c  = sel_cnt == SEL_L;
    last_pair_c = side_b & sel_wrap_c & pair_wrap_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LO;
      S_LO:    if (accept_c) state_nx = S_HI;
      S_HI:    if (accept_c) state_nx = last_pair_c ? S_FIN : S_LO;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake/status flops follow the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready <= 1'b0;
      busy    <= 1'b0;
    end else begin
      s_ready <= (state_nx == S_LO) || (state_nx == S_HI);
      busy    <= state_nx != S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_cnt  <= '0;
      sel_cnt   <= '0;
      side_b    <= 1'b0;
      lo_q      <= '0;
      err       <= 1'b0;
      vec_din_1 <= '0;
      vec_din_2 <= '0;
      vec_index <= '0;
      vec_sel   <= '0;
      vec_we_a  <= 1'b0;
      vec_we_b  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      vec_we_a  <= 1'b0;
      vec_we_b  <= 1'b0;
      load_done <= 1'b0;
      if (state == S_IDLE && start) begin
        pair_cnt <= '0;
        sel_cnt  <= '0;
        side_b   <= 1'b0;
        err      <= 1'b0;
      end
      if (accept_c && ge_2q_c) err <= 1'b1;
      if (accept_c && state == S_LO) lo_q <= red_c;
      if (accept_c && state == S_HI) begin
        vec_din_1 <= lo_q;
        vec_din_2 <= red_c;
        vec_index <= {pair_cnt, 1'b0};
        vec_sel   <= sel_cnt;
        vec_we_a  <= ~side_b;
        vec_we_b  <= side_b;
        load_done <= last_pair_c;
        pair_cnt  <= pair_wrap_c ? '0 : pair_cnt + PW'(1);
        if (pair_wrap_c) begin
          sel_cnt <= sel_wrap_c ? 2'd0 : sel_cnt + 2'd1;
          if (sel_wrap_c) side_b <= ~side_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_polyvec_coeff_feeder.sv
// Directed bench for polyvec_coeff_feeder: reduction table, full loads, gaps, mid-load start and reset.
module tb_polyvec_coeff_feeder;

  localparam int N = 256;
  localparam int K = 3;
  localparam int DEPTH = 8;
  localparam int TOT = 2 * K * N;
  localparam int PAIRS_SIDE = K * N / 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready;
  logic [15:0] vec_din_1, vec_din_2;
  logic [DEPTH-1:0] vec_index;
  logic [1:0] vec_sel;
  logic vec_we_a, vec_we_b, busy, load_done, err;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       b;
    logic [7:0] idx;
    logic [1:0] sel;
    logic [15:0] d1;
    logic [15:0] d2;
    logic       ld;
  } strobe_t;

  strobe_t q[$];

  typedef struct {
    logic [15:0] lo_in;
    logic [15:0] hi_in;
    logic [15:0] exp_d1;
    logic [15:0] exp_d2;
    logic        exp_err;
  } vec_t;

  polyvec_coeff_feeder #(.N(N), .K(K), .DEPTH(DEPTH), .Q(3329)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .vec_din_1(vec_din_1), .vec_din_2(vec_din_2),
    .vec_index(vec_index), .vec_sel(vec_sel), .vec_we_a(vec_we_a), .vec_we_b(vec_we_b),
    .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!reset && (vec_we_a || vec_we_b || load_done))
      q.push_back('{b: vec_we_b, idx: vec_index, sel: vec_sel, d1: vec_din_1, d2: vec_din_2, ld: load_done});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] data_fn(input int k);
    return 16'((k * 13) % 6658);
  endfunction

  function automatic logic [15:0] red(input logic [15:0] x);
    return (x >= 16'd3329) ? x - 16'd3329 : x;
  endfunction

  task automatic send(input logic [15:0] x);
    bit ok;
    s_valid = 1'b1;
    s_data = x;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    check("send timeout", 64'(0), 64'(1));
  endtask

  task automatic pulse_start();
    s_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("after start s_ready,busy,err", 64'({s_ready, busy, err}), 64'(3'b110));
  endtask

  task automatic finish_checks(input string tag);
    check({tag, " FIN ld,we_b,we_a,busy,s_ready"},
          64'({load_done, vec_we_b, vec_we_a, busy, s_ready}), 64'(5'b11010));
    @(posedge clk);
    #1;
    check({tag, " idle ld,we_b,busy,s_ready"},
          64'({load_done, vec_we_b, busy, s_ready}), 64'(4'b0000));
  endtask

  task automatic verify_load(input string tag);
    int na, nld, pp;
    strobe_t e;
    na = 0;
    nld = 0;
    check({tag, " strobe count"}, 64'(q.size()), 64'(K * N));
    foreach (q[i]) begin
      pp = i % PAIRS_SIDE;
      e.b = (i >= PAIRS_SIDE);
      e.sel = 2'(pp / (N / 2));
      e.idx = 8'(2 * (pp % (N / 2)));
      e.d1 = red(data_fn(2 * i));
      e.d2 = red(data_fn(2 * i + 1));
      e.ld = (i == K * N - 1);
      if (!q[i].b) na++;
      if (q[i].ld) nld++;
      check($sformatf("%s strobe %0d", tag, i), 64'(q[i]), 64'(e));
    end
    check({tag, " A strobes"}, 64'(na), 64'(PAIRS_SIDE));
    check({tag, " load_done pulses"}, 64'(nld), 64'(1));
  endtask

  task automatic run_load(input string tag, input bit gaps, input bit midstart);
    q.delete();
    pulse_start();
    for (int k = 0; k < TOT; k++) begin
      if (gaps && $urandom_range(1) == 1) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (midstart && k == 200) begin
        pulse_start();
      end
      send(data_fn(k));
    end
    s_valid = 1'b0;
    finish_checks(tag);
    verify_load(tag);
  endtask

  initial begin
    vec_t tv[5];
    tv[0] = '{16'd0,     16'd1,    16'd0,     16'd1,    1'b0};
    tv[1] = '{16'd3328,  16'd3329, 16'd3328,  16'd0,    1'b0};
    tv[2] = '{16'd6657,  16'd6658, 16'd3328,  16'd3329, 1'b1};
    tv[3] = '{16'd100,   16'd200,  16'd100,   16'd200,  1'b1};
    tv[4] = '{16'd65535, 16'd3330, 16'd62206, 16'd1,    1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 64'({s_ready, busy, load_done, vec_we_a, vec_we_b, err,
                                vec_din_1, vec_din_2, vec_index, vec_sel}), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Gap-free load plus explicit A->B boundary.
    run_load("nogap", 1'b0, 1'b0);
    check("boundary A last", 64'({q[383].b, q[383].idx, q[383].sel}), 64'({1'b0, 8'd254, 2'd2}));
    check("boundary B first", 64'({q[384].b, q[384].idx, q[384].sel}), 64'({1'b1, 8'd0, 2'd0}));
    check("first strobe data", 64'({q[0].d1, q[0].d2}), 64'({16'd0, 16'd13}));

    // Reduction table and sticky err.
    q.delete();
    pulse_start();
    for (int j = 0; j < 5; j++) begin
      send(tv[j].lo_in);
      send(tv[j].hi_in);
      check($sformatf("table %0d we_a,idx,sel,d1,d2", j),
            64'({vec_we_a, vec_we_b, vec_index, vec_sel, vec_din_1, vec_din_2}),
            64'({1'b1, 1'b0, 8'(2 * j), 2'd0, tv[j].exp_d1, tv[j].exp_d2}));
      check($sformatf("table %0d err", j), 64'(err), 64'(tv[j].exp_err));
    end
    for (int k = 10; k < TOT; k++) send(16'd0);
    s_valid = 1'b0;
    finish_checks("table");
    check("err sticky after load", 64'(err), 64'(1));

    // Gapped load with an ignored start at pair 100; start clears err.
    run_load("gap", 1'b1, 1'b1);

    // Reset after 700 accepts, then a clean restart.
    q.delete();
    pulse_start();
    for (int k = 0; k < 700; k++) send(data_fn(k));
    check("strobes before reset", 64'(q.size()), 64'(349));
    #1;
    reset = 1'b1;
    #1;
    check("reset mid-load outputs", 64'({s_ready, busy, load_done, vec_we_a, vec_we_b, err,
                                         vec_din_1, vec_din_2, vec_index, vec_sel}), 64'(0));
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_load("restart", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/polyvec_coeff_feeder.md
# polyvec_coeff_feeder

Transmit-side companion of the polyvec basemul accumulator: accepts a serial stream of 16-bit polynomial coefficients and delivers them as coefficient pairs with even RAM indices and per-polynomial select onto the accumulator's A and B load ports. One load = all K polynomials of vector A, then all K polynomials of vector B. Each coefficient is conditionally reduced mod q on entry; out-of-range inputs are flagged. Sits between the coefficient source (sampler/decoder) and the accumulator load interface.

## Interface
- N, 256, coefficients per polynomial (even, power of two)
- K, 3, polynomials per vector (2..4)
- DEPTH, 8, index width, log2(N)
- Q, 3329, modulus for input reduction
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; reset reset, clock clk
- start  in  1  pulse; begins a load when idle, ignored when busy
- s_valid  in  1  upstream coefficient valid
- s_data  in  16  upstream coefficient, unsigned
- s_ready  out  1  coefficient accepted when s_valid & s_ready
- vec_din_1  out  16  even coefficient (index vec_index)
- vec_din_2  out  16  odd coefficient (index vec_index+1)
- vec_index  out  DEPTH  even pair index, 0..N-2
- vec_sel  out  2  polynomial number 0..K-1
- vec_we_a  out  1  one-cycle write strobe, vector A
- vec_we_b  out  1  one-cycle write strobe, vector B
- busy  out  1  high from start acceptance until load_done cycle inclusive
- load_done  out  1  one-cycle pulse on the final pair write
- err  out  1  sticky; a coefficient ≥ 2Q was accepted this load

## Operation
- States: IDLE, LO (await even coeff), HI (await odd coeff), FIN.
- IDLE: s_ready=0, busy=0. start → LO; clears pair counter, vec_sel, side bit (A), err.
- LO: s_ready=1. On accept: store reduced coeff in lo register → HI.
- HI: s_ready=1. On accept: register pair {lo, reduced coeff}, vec_index=2*pair_cnt, vec_sel, side; assert vec_we_a (side A) or vec_we_b (side B) next cycle. If this was the last pair of side B poly K-1 → FIN, else → LO.
- Counters after each pair: pair_cnt wraps N/2-1→0 and increments vec_sel; vec_sel wraps K-1→0 and flips side A→B.
- FIN: final write strobe and load_done both asserted this cycle; s_ready=0 → IDLE.
- Reduction: r = (x ≥ Q) ? x−Q : x, 16-bit. If x ≥ 2Q, err set, r still x−Q (not further reduced).
- Total accepts per load: 2·K·N (1536 default); exactly K·N/2 strobes per side.
- start while busy: ignored, no state change. s_valid low: state holds, no strobe.
- Outputs vec_din_*, vec_index, vec_sel hold last written values between strobes.

## Timing
- Reset values: s_ready=0, busy=0, load_done=0, vec_we_a=0, vec_we_b=0, err=0, vec_din_1=0, vec_din_2=0, vec_index=0, vec_sel=0; state IDLE.
- start sampled at cycle t → s_ready=1 at t+1.
- Odd coefficient accepted at cycle t → write strobe with valid pair/index/sel at t+1; s_ready already high at t+1 for next even coeff (no bubble). Max throughput: one coefficient per cycle, one strobe per two cycles.
- Last accept at t → FIN at t+1 (strobe + load_done) → IDLE at t+2; start accepted at t+2 earliest.
- err updates the cycle after the offending accept.
- reset mid-load: immediate abort, all outputs to reset values, partial data discarded; no load_done.

## Test plan
- K=3, N=256, stream 0..1535 with s_valid always high → 384 strobes on vec_we_a (sel 0,1,2; index 0..254) then 384 on vec_we_b; first A strobe din=(0,1) idx 0; coeff 3329 emitted as 0; load_done with final B strobe, busy low next cycle.
- Random s_valid gaps (50%) → identical strobe sequence and data to gap-free run; no strobe without a completed pair.
- Coeffs 3328, 3329, 6657, 6658 → outputs 3328, 0, 3328, 3329; err rises after 6658, stays high until next start.
- start pulsed mid-load at pair 100 → ignored, sequence continues, single load_done.
- reset asserted after 700 accepts → all outputs zero immediately; new start restarts from side A, sel 0, index 0.
- Boundary: pair 127 of sel 2 side A followed by next pair → strobe vec_we_a idx 254 sel 2, then vec_we_b idx 0 sel 0.
